// File: rtl/traffic_phase_scheduler_if.sv
// Signal bundle between the intersection sensors/lamps and the phase scheduler.
// The slave view belongs to the scheduler: it takes the requests and drives the lamps.
interface traffic_phase_scheduler_if;
  logic       ns_req_i;
  logic       ew_req_i;
  logic       ped_req_i;
  logic [2:0] ns_o;
  logic [2:0] ew_o;
  logic       walk_o;
  logic       ped_ack_o;
  logic [2:0] phase_o;

  modport master (
    output ns_req_i, ew_req_i, ped_req_i,
    input  ns_o, ew_o, walk_o, ped_ack_o, phase_o
  );

  modport slave (
    input  ns_req_i, ew_req_i, ped_req_i,
    output ns_o, ew_o, walk_o, ped_ack_o, phase_o
  );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Demand-driven phase scheduler for a two-approach intersection with a walk phase.
// Greens are held between a minimum and (under conflicting demand) a maximum time,
// followed by yellow and all-red clearance; pedestrian requests insert a WALK phase.
module traffic_phase_scheduler #(
  parameter int TW        = 8,
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 12,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 6
) (
  input logic                      clk,
  input logic                      rst,
  traffic_phase_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    ALL_RED   = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    WALK      = 3'd5
  } state_e;

  localparam logic [TW-1:0] MIN_LAST    = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MAX_LAST    = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] YELLOW_LAST = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] ALLRED_LAST = TW'(ALLRED_T - 1);
  localparam logic [TW-1:0] WALK_LAST   = TW'(WALK_T - 1);

  localparam logic LG_NS = 1'b0;
  localparam logic LG_EW = 1'b1;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            pedPend_q, pedPend_d;
  logic            lastGreen_q, lastGreen_d;
  logic            pedAck_q, pedAck_d;
  logic            nsYield;
  logic            ewYield;
  logic            inGreen;
  logic            stateChange;
  logic            enterWalk;

  assign nsYield = (timer_q >= MIN_LAST) && (bus.ew_req_i || pedPend_q) &&
                   (!bus.ns_req_i || (timer_q >= MAX_LAST));
  assign ewYield = (timer_q >= MIN_LAST) && (bus.ns_req_i || pedPend_q) &&
                   (!bus.ew_req_i || (timer_q >= MAX_LAST));
  assign inGreen     = (state_q == NS_GREEN) || (state_q == EW_GREEN);
  assign stateChange = (state_d != state_q);
  assign enterWalk   = (state_d == WALK) && (state_q != WALK);

  // State register; reset aborts any phase straight to all-red.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ALL_RED;
    end else begin
      state_q <= state_d;
    end
  end

  // Phase timer, pending walk request, last served approach and walk acknowledge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      timer_q     <= '0;
      pedPend_q   <= 1'b0;
      lastGreen_q <= LG_EW;
      pedAck_q    <= 1'b0;
    end else begin
      timer_q     <= timer_d;
      pedPend_q   <= pedPend_d;
      lastGreen_q <= lastGreen_d;
      pedAck_q    <= pedAck_d;
    end
  end

  // Next-state selection from the current phase, its timer and the demand.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ALL_RED: begin
        if (timer_q == ALLRED_LAST) begin
          if (pedPend_q) begin
            state_d = WALK;
          end else if (lastGreen_q == LG_EW) begin
            state_d = NS_GREEN;
          end else begin
            state_d = EW_GREEN;
          end
        end
      end
      NS_GREEN:  if (nsYield) state_d = NS_YELLOW;
      NS_YELLOW: if (timer_q == YELLOW_LAST) state_d = ALL_RED;
      EW_GREEN:  if (ewYield) state_d = EW_YELLOW;
      EW_YELLOW: if (timer_q == YELLOW_LAST) state_d = ALL_RED;
      WALK:      if (timer_q == WALK_LAST) state_d = ALL_RED;
      default:   state_d = ALL_RED;
    endcase
  end

  // Timer restarts on every phase change and saturates in green; clearing the walk request wins over a new press.
  always_comb begin
    timer_d     = timer_q + TW'(1);
    pedPend_d   = pedPend_q;
    lastGreen_d = lastGreen_q;
    pedAck_d    = enterWalk;
    if (stateChange) begin
      timer_d = '0;
    end else if (inGreen && (timer_q >= MAX_LAST)) begin
      timer_d = timer_q;
    end
    if (enterWalk) begin
      pedPend_d = 1'b0;
    end else if (bus.ped_req_i && (state_q != WALK)) begin
      pedPend_d = 1'b1;
    end
    if (stateChange && (state_d == NS_GREEN)) begin
      lastGreen_d = LG_NS;
    end else if (stateChange && (state_d == EW_GREEN)) begin
      lastGreen_d = LG_EW;
    end
  end

  // Moore lamp decode from the current phase only.
  always_comb begin
    bus.ns_o      = LAMP_RED;
    bus.ew_o      = LAMP_RED;
    bus.walk_o    = 1'b0;
    bus.ped_ack_o = pedAck_q;
    bus.phase_o   = state_q;
    case (state_q)
      NS_GREEN:  bus.ns_o   = LAMP_GREEN;
      NS_YELLOW: bus.ns_o   = LAMP_YELLOW;
      EW_GREEN:  bus.ew_o   = LAMP_GREEN;
      EW_YELLOW: bus.ew_o   = LAMP_YELLOW;
      WALK:      bus.walk_o = 1'b1;
      default:   bus.walk_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for the traffic phase scheduler, followed by a random-demand safety run.
module tb_traffic_phase_scheduler;

  localparam logic [2:0] PH_ALL_RED   = 3'd0;
  localparam logic [2:0] PH_NS_GREEN  = 3'd1;
  localparam logic [2:0] PH_NS_YELLOW = 3'd2;
  localparam logic [2:0] PH_EW_GREEN  = 3'd3;
  localparam logic [2:0] PH_EW_YELLOW = 3'd4;
  localparam logic [2:0] PH_WALK      = 3'd5;

  logic clk;
  logic rst;
  int   vecCount;
  int   missCount;

  traffic_phase_scheduler_if bus ();

  traffic_phase_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, wanted %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [6:0] expLamps(input logic [2:0] ph);
    case (ph)
      PH_NS_GREEN:  return {3'b001, 3'b100, 1'b0};
      PH_NS_YELLOW: return {3'b010, 3'b100, 1'b0};
      PH_EW_GREEN:  return {3'b100, 3'b001, 1'b0};
      PH_EW_YELLOW: return {3'b100, 3'b010, 1'b0};
      PH_WALK:      return {3'b100, 3'b100, 1'b1};
      default:      return {3'b100, 3'b100, 1'b0};
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkState(input string tag, input logic [2:0] ph, input logic ack);
    checkOutput({tag, ".phase"}, 32'(bus.phase_o), 32'(ph));
    checkOutput({tag, ".lamps"}, 32'({bus.ns_o, bus.ew_o, bus.walk_o}), 32'(expLamps(ph)));
    checkOutput({tag, ".ack"}, 32'(bus.ped_ack_o), 32'(ack));
  endtask

  task automatic expectRun(input string tag, input logic [2:0] ph, input int n,
                           input logic ackFirst);
    for (int i = 0; i < n; i++) begin
      checkState($sformatf("%s[%0d]", tag, i), ph, ackFirst && (i == 0));
      step();
    end
  endtask

  task automatic doReset(input string tag);
    rst = 1'b0;
    step();
    checkState({tag, ".inReset"}, PH_ALL_RED, 1'b0);
    rst = 1'b1;
    step();
  endtask

  task automatic applyStimulus(input logic ns, input logic ew, input logic ped);
    bus.ns_req_i  = ns;
    bus.ew_req_i  = ew;
    bus.ped_req_i = ped;
  endtask

  // Directed scenarios, then the random safety run and the summary.
  initial begin
    logic [2:0] prevPhase;
    logic       bothLit;
    vecCount  = 0;
    missCount = 0;
    rst       = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);

    doReset("idle");
    expectRun("idleNs", PH_NS_GREEN, 50, 1'b0);

    doReset("ewDemand");
    expectRun("ewG0", PH_NS_GREEN, 1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    expectRun("ewNsG", PH_NS_GREEN, 3, 1'b0);
    expectRun("ewNsY", PH_NS_YELLOW, 2, 1'b0);
    expectRun("ewAr", PH_ALL_RED, 1, 1'b0);
    expectRun("ewEwG", PH_EW_GREEN, 5, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    doReset("both");
    applyStimulus(1'b1, 1'b1, 1'b0);
    expectRun("bothNsG", PH_NS_GREEN, 12, 1'b0);
    expectRun("bothNsY", PH_NS_YELLOW, 2, 1'b0);
    expectRun("bothAr1", PH_ALL_RED, 1, 1'b0);
    expectRun("bothEwG", PH_EW_GREEN, 12, 1'b0);
    expectRun("bothEwY", PH_EW_YELLOW, 2, 1'b0);
    expectRun("bothAr2", PH_ALL_RED, 1, 1'b0);
    expectRun("bothNsG2", PH_NS_GREEN, 1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    doReset("ped");
    applyStimulus(1'b0, 1'b0, 1'b1);
    expectRun("pedG0", PH_NS_GREEN, 1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    expectRun("pedNsG", PH_NS_GREEN, 3, 1'b0);
    expectRun("pedNsY", PH_NS_YELLOW, 2, 1'b0);
    expectRun("pedAr1", PH_ALL_RED, 1, 1'b0);
    expectRun("pedWalkA", PH_WALK, 2, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    expectRun("pedWalkB", PH_WALK, 1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    expectRun("pedWalkC", PH_WALK, 3, 1'b0);
    expectRun("pedAr2", PH_ALL_RED, 1, 1'b0);
    expectRun("pedEwG", PH_EW_GREEN, 20, 1'b0);

    applyStimulus(1'b1, 1'b0, 1'b0);
    expectRun("rstEwG", PH_EW_GREEN, 1, 1'b0);
    expectRun("rstEwY", PH_EW_YELLOW, 1, 1'b0);
    doReset("rstInYellow");
    applyStimulus(1'b0, 1'b0, 1'b0);
    expectRun("rstYNs", PH_NS_GREEN, 3, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    expectRun("rstWG3", PH_NS_GREEN, 1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    expectRun("rstWG4", PH_NS_GREEN, 1, 1'b0);
    expectRun("rstWY", PH_NS_YELLOW, 2, 1'b0);
    expectRun("rstWAr", PH_ALL_RED, 1, 1'b0);
    expectRun("rstWalk", PH_WALK, 3, 1'b1);
    doReset("rstInWalk");
    expectRun("rstWNs", PH_NS_GREEN, 10, 1'b0);

    prevPhase = bus.phase_o;
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(($urandom % 3) == 0, ($urandom % 3) == 0, ($urandom % 16) == 0);
      step();
      bothLit = (bus.ns_o != 3'b100) && (bus.ew_o != 3'b100);
      checkOutput("rndExclusive", 32'(bothLit), 32'd0);
      checkOutput("rndLegalPhase", 32'(bus.phase_o < 3'd6), 32'd1);
      if (bus.walk_o) begin
        checkOutput("rndWalkRed", 32'({bus.ns_o, bus.ew_o}), 32'({3'b100, 3'b100}));
      end
      if (((bus.phase_o == PH_NS_GREEN) || (bus.phase_o == PH_EW_GREEN)) &&
          (bus.phase_o != prevPhase)) begin
        checkOutput("rndGreenAfterRed", 32'(prevPhase), 32'(PH_ALL_RED));
      end
      if (bus.ped_ack_o) begin
        checkOutput("rndAckInWalk", 32'(bus.phase_o), 32'(PH_WALK));
      end
      prevPhase = bus.phase_o;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
- Demand-driven phase scheduler for a two-approach intersection with a pedestrian crossing.
- Decides which approach (NS or EW) gets green, when to change, and when to insert a pedestrian walk phase.
- Inputs are vehicle sensor levels and a pedestrian push-button pulse; outputs are one-hot light heads plus a walk lamp.
- Replaces fixed-period cycling with min/max-green timing, yellow and all-red clearance intervals.

Parameters:
- TW, 8: timer width in bits.
- MIN_GREEN, 4: minimum green duration in cycles (>=1).
- MAX_GREEN, 12: maximum green duration when a conflicting demand is present (>=MIN_GREEN, <2^TW).
- YELLOW_T, 2: yellow duration in cycles (>=1).
- ALLRED_T, 1: all-red clearance duration in cycles (>=1).
- WALK_T, 6: pedestrian walk duration in cycles (>=1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- ns_req  in  1  NS vehicle sensor; level, high = vehicle waiting or present.
- ew_req  in  1  EW vehicle sensor; level.
- ped_req  in  1  pedestrian button; any high cycle registers a request.
- NS  out  3  NS head {R,Y,G}: RED=100, YELLOW=010, GREEN=001.
- EW  out  3  EW head, same encoding.
- walk  out  1  pedestrian walk lamp.
- ped_ack  out  1  one-cycle pulse on the first cycle of WALK.
- phase  out  3  current state code, for debug/status.

Behaviour:
- States and phase codes: ALL_RED=0, NS_GREEN=1, NS_YELLOW=2, EW_GREEN=3, EW_YELLOW=4, WALK=5. Codes 6 and 7 are illegal and go to ALL_RED next cycle.
- Lamp decode is Moore, from state only:
  - NS head is GREEN only in NS_GREEN, YELLOW only in NS_YELLOW, otherwise RED.
  - EW head follows the same rule for EW_GREEN and EW_YELLOW.
  - walk=1 only in WALK.
- timer clears to 0 on every state change and otherwise increments by 1 each cycle. In green states it saturates at MAX_GREEN-1.
- ped_pend: set by ped_req in any state except WALK (requests during WALK are ignored); cleared on entry to WALK. If set and clear coincide, clear wins.
- last_green: 1-bit register, updated on entry to NS_GREEN or EW_GREEN.
- On rst=0 at a clock edge:
  - state=ALL_RED, timer=0, ped_pend=0, last_green=EW.
  - Outputs: NS=100, EW=100, walk=0, ped_ack=0, phase=0.
  - Reset mid-phase aborts immediately with no yellow.
- ALL_RED: exit when timer==ALLRED_T-1.
  - If ped_pend, go to WALK.
  - Else go to green of the approach opposite last_green (NS if last_green=EW).
- NS_GREEN:
  - conflict = ew_req | ped_pend.
  - Go to NS_YELLOW when timer>=MIN_GREEN-1 AND conflict AND (!ns_req OR timer>=MAX_GREEN-1).
  - Without conflict, hold green indefinitely.
- EW_GREEN: same rule with ns_req and ew_req swapped.
- NS_YELLOW / EW_YELLOW: go to ALL_RED when timer==YELLOW_T-1.
- WALK: go to ALL_RED when timer==WALK_T-1. ped_ack is registered high for exactly the first WALK cycle.
- Dwell times:
  - Yellow, all-red and walk last exactly YELLOW_T, ALLRED_T and WALK_T cycles.
  - Green lasts at least MIN_GREEN and, under conflict, at most MAX_GREEN cycles.
- Both heads are never non-RED in the same cycle. walk=1 implies both heads are RED.

Test Plan:
- Reset then release, no requests: 1 cycle ALL_RED, then NS=001 and EW=100, held for 50+ cycles; ped_ack never pulses.
- In NS_GREEN, ns_req=0, assert ew_req at green cycle 1:
  - NS green for exactly 4 cycles, 2 yellow, 1 all-red, then EW=001.
  - Sequence of NS values: 001×4, 010×2, 100.
- ns_req and ew_req both held high: NS green lasts 12 cycles; with defaults the full cycle is NS_GREEN 12, NS_YELLOW 2, ALL_RED 1, EW_GREEN 12, EW_YELLOW 2, ALL_RED 1.
- One-cycle ped_req pulse during NS_GREEN at cycle 0 with no vehicle demand:
  - Expected sequence: NS green 4, yellow 2, all-red 1, WALK 6 (walk=1, ped_ack on first cycle only), all-red 1, then EW_GREEN.
  - A second ped_req pulse during WALK is ignored, and no second WALK follows.
- rst=0 asserted during EW_YELLOW and during WALK: the next cycle shows NS=EW=100, walk=0, phase=0. After release the first green is NS.
- Assertion-based bench over 10k cycles of random requests:
  - Never NS≠100 and EW≠100 together.
  - walk=1 only with both heads RED.
  - Every green is preceded by at least 1 all-red cycle.
  - phase never reads 6 or 7.
